// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// mem_stage: LoongArch MEM stage. Waits for the load response, aligns it, then
// hands the result to WB. Optional macro: MEM_EARLY_LOAD_FWD_EN. Revision 1.0
// ============================================================================
module mem_stage #(
   parameter int PASS_W   = 128,
   parameter int ERTN_BIT = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              EX_to_MEM_valid,
   input  logic              ex_gr_we,
   input  logic [4:0]        ex_dest,
   input  logic [31:0]       ex_result,
   input  logic [31:0]       ex_pc,
   input  logic              ex_mem_req,
   input  logic [4:0]        ex_load_op,
   input  logic [PASS_W-1:0] ex_pass,
   input  logic              ex_has_ex,
   input  logic              data_sram_data_ok,
   input  logic [31:0]       data_sram_rdata,
   input  logic              WB_allow,
   input  logic              wb_flush,
   output logic              MEM_allow,
   output logic              MEM_to_WB_valid,
   output logic              mem_gr_we,
   output logic [4:0]        mem_dest,
   output logic [31:0]       mem_final_result,
   output logic [31:0]       mem_pc,
   output logic [PASS_W-1:0] mem_pass,
   output logic [4:0]        mem_fwd_dest,
   output logic [31:0]       mem_fwd_value,
   output logic              mem_fwd_busy,
   output logic              mem_ex
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_READY = 2'd2} state_t;

   state_t            state_q, state_d;
   logic              valid_q, valid_d;
   logic              discard_q, discard_d;
   logic [31:0]       rdata_buf_q, rdata_buf_d;
   logic              gr_we_q, gr_we_d;
   logic [4:0]        dest_q, dest_d;
   logic [31:0]       result_q, result_d;
   logic [31:0]       pc_q, pc_d;
   logic [4:0]        load_op_q, load_op_d;
   logic [PASS_W-1:0] pass_q, pass_d;
   logic              has_ex_q, has_ex_d;

   logic mem_go, capture, resp_live, is_load, early_hit;

   function automatic logic [31:0] align_load(input logic [31:0] word,
                                              input logic [1:0]  off,
                                              input logic [4:0]  op);
      logic [31:0] raw;
      raw = word >> {off, 3'b000};
      if (op[0])      return {{24{raw[7]}}, raw[7:0]};
      else if (op[1]) return {24'd0, raw[7:0]};
      else if (op[2]) return {{16{raw[15]}}, raw[15:0]};
      else if (op[3]) return {16'd0, raw[15:0]};
      else            return raw;
   endfunction

   assign mem_go    = (state_q == S_READY);
   assign MEM_allow = !valid_q || (mem_go && WB_allow);
   assign capture   = EX_to_MEM_valid && MEM_allow;
   // A response only belongs to the held load when no discard is pending.
   assign resp_live = (state_q == S_WAIT) && data_sram_data_ok && !discard_q;
   assign is_load   = (load_op_q != 5'd0);

`ifdef MEM_EARLY_LOAD_FWD_EN
   assign early_hit = resp_live;
`else
   assign early_hit = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      valid_d     = valid_q;
      discard_d   = discard_q;
      rdata_buf_d = rdata_buf_q;
      gr_we_d     = gr_we_q;
      dest_d      = dest_q;
      result_d    = result_q;
      pc_d        = pc_q;
      load_op_d   = load_op_q;
      pass_d      = pass_q;
      has_ex_d    = has_ex_q;

      if (data_sram_data_ok && discard_q)
         discard_d = 1'b0;

      if (wb_flush) begin
         valid_d = 1'b0;
         state_d = S_IDLE;
         if (state_q == S_WAIT && !resp_live)
            discard_d = 1'b1;
      end else if (capture) begin
         valid_d   = 1'b1;
         state_d   = ex_mem_req ? S_WAIT : S_READY;
         gr_we_d   = ex_gr_we;
         dest_d    = ex_dest;
         result_d  = ex_result;
         pc_d      = ex_pc;
         load_op_d = ex_load_op;
         pass_d    = ex_pass;
         has_ex_d  = ex_has_ex;
      end else if (resp_live) begin
         state_d     = S_READY;
         rdata_buf_d = data_sram_rdata;
      end else if (mem_go && WB_allow) begin
         valid_d = 1'b0;
         state_d = S_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         valid_q     <= 1'b0;
         discard_q   <= 1'b0;
         rdata_buf_q <= '0;
         gr_we_q     <= 1'b0;
         dest_q      <= '0;
         result_q    <= '0;
         pc_q        <= '0;
         load_op_q   <= '0;
         pass_q      <= '0;
         has_ex_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         valid_q     <= valid_d;
         discard_q   <= discard_d;
         rdata_buf_q <= rdata_buf_d;
         gr_we_q     <= gr_we_d;
         dest_q      <= dest_d;
         result_q    <= result_d;
         pc_q        <= pc_d;
         load_op_q   <= load_op_d;
         pass_q      <= pass_d;
         has_ex_q    <= has_ex_d;
      end
   end

   assign MEM_to_WB_valid  = valid_q && mem_go && !wb_flush;
   assign mem_gr_we        = gr_we_q;
   assign mem_dest         = dest_q;
   assign mem_pc           = pc_q;
   assign mem_pass         = pass_q;
   assign mem_final_result = is_load ? align_load(rdata_buf_q, result_q[1:0], load_op_q)
                                     : result_q;
   assign mem_fwd_dest     = (valid_q && gr_we_q) ? dest_q : 5'd0;
   assign mem_fwd_busy     = valid_q && gr_we_q && is_load && !mem_go && !early_hit;
   assign mem_fwd_value    = early_hit ? align_load(data_sram_rdata, result_q[1:0], load_op_q)
                                       : mem_final_result;
   assign mem_ex           = valid_q && (has_ex_q || pass_q[ERTN_BIT]);

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// tb_mem_stage: directed self-checking bench for mem_stage. Revision 1.0
// ============================================================================
module tb_mem_stage;
   localparam int PASS_W = 128;
   localparam logic [4:0] LD_B  = 5'b00001;
   localparam logic [4:0] LD_BU = 5'b00010;
   localparam logic [4:0] LD_H  = 5'b00100;
   localparam logic [4:0] LD_HU = 5'b01000;
   localparam logic [4:0] LD_W  = 5'b10000;
   localparam logic [4:0] ALU   = 5'b00000;

   logic              clk = 1'b0;
   logic              reset;
   logic              EX_to_MEM_valid, ex_gr_we, ex_mem_req, ex_has_ex;
   logic [4:0]        ex_dest, ex_load_op;
   logic [31:0]       ex_result, ex_pc;
   logic [PASS_W-1:0] ex_pass;
   logic              data_sram_data_ok, WB_allow, wb_flush;
   logic [31:0]       data_sram_rdata;
   logic              MEM_allow, MEM_to_WB_valid, mem_gr_we, mem_fwd_busy, mem_ex;
   logic [4:0]        mem_dest, mem_fwd_dest;
   logic [31:0]       mem_final_result, mem_pc, mem_fwd_value;
   logic [PASS_W-1:0] mem_pass;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   mem_stage #(.PASS_W(PASS_W)) dut (
      .clk(clk), .reset(reset),
      .EX_to_MEM_valid(EX_to_MEM_valid), .ex_gr_we(ex_gr_we), .ex_dest(ex_dest),
      .ex_result(ex_result), .ex_pc(ex_pc), .ex_mem_req(ex_mem_req),
      .ex_load_op(ex_load_op), .ex_pass(ex_pass), .ex_has_ex(ex_has_ex),
      .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
      .WB_allow(WB_allow), .wb_flush(wb_flush),
      .MEM_allow(MEM_allow), .MEM_to_WB_valid(MEM_to_WB_valid),
      .mem_gr_we(mem_gr_we), .mem_dest(mem_dest), .mem_final_result(mem_final_result),
      .mem_pc(mem_pc), .mem_pass(mem_pass), .mem_fwd_dest(mem_fwd_dest),
      .mem_fwd_value(mem_fwd_value), .mem_fwd_busy(mem_fwd_busy), .mem_ex(mem_ex)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_ex(input logic [4:0] op, input logic req, input logic [31:0] res,
                           input logic [4:0] dst, input logic [31:0] pc);
      EX_to_MEM_valid = 1'b1;
      ex_gr_we        = 1'b1;
      ex_dest         = dst;
      ex_result       = res;
      ex_pc           = pc;
      ex_mem_req      = req;
      ex_load_op      = op;
      ex_pass         = '0;
      ex_has_ex       = 1'b0;
   endtask

   task automatic idle_ex();
      EX_to_MEM_valid = 1'b0;
   endtask

   task automatic run_load(input string tag, input logic [4:0] op, input logic [31:0] addr,
                           input logic [4:0] dst, input logic [31:0] rdata, input int lat,
                           input logic [31:0] exp);
      drive_ex(op, 1'b1, addr, dst, 32'h1c00_0100);
      step();
      idle_ex();
      for (int i = 1; i < lat; i++) begin
         #1;
         check({tag, " wait busy"},  32'(mem_fwd_busy),    32'd1);
         check({tag, " wait allow"}, 32'(MEM_allow),       32'd0);
         check({tag, " wait towb"},  32'(MEM_to_WB_valid), 32'd0);
         check({tag, " wait dest"},  32'(mem_fwd_dest),    32'(dst));
         step();
      end
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = rdata;
      #1;
`ifdef MEM_EARLY_LOAD_FWD_EN
      check({tag, " dok busy"}, 32'(mem_fwd_busy), 32'd0);
      check({tag, " dok fwd"},  mem_fwd_value,     exp);
`else
      check({tag, " dok busy"}, 32'(mem_fwd_busy), 32'd1);
`endif
      step();
      data_sram_data_ok = 1'b0;
      #1;
      check({tag, " towb"},   32'(MEM_to_WB_valid), 32'd1);
      check({tag, " result"}, mem_final_result,     exp);
      check({tag, " fwdval"}, mem_fwd_value,        exp);
      check({tag, " busy"},   32'(mem_fwd_busy),    32'd0);
      step();
   endtask

   initial begin
      reset = 1'b1;
      EX_to_MEM_valid = 1'b0; ex_gr_we = 1'b0; ex_dest = '0; ex_result = '0; ex_pc = '0;
      ex_mem_req = 1'b0; ex_load_op = '0; ex_pass = '0; ex_has_ex = 1'b0;
      data_sram_data_ok = 1'b0; data_sram_rdata = '0; WB_allow = 1'b1; wb_flush = 1'b0;
      step();
      step();
      reset = 1'b0;
      #1;
      check("rst towb",   32'(MEM_to_WB_valid), 32'd0);
      check("rst allow",  32'(MEM_allow),       32'd1);
      check("rst result", mem_final_result,     32'd0);
      check("rst fdest",  32'(mem_fwd_dest),    32'd0);
      check("rst busy",   32'(mem_fwd_busy),    32'd0);
      check("rst ex",     32'(mem_ex),          32'd0);
      step();

      // ALU op passes straight through
      drive_ex(ALU, 1'b0, 32'h0000_1234, 5'd5, 32'h1c00_0000);
      step();
      idle_ex();
      #1;
      check("alu towb",   32'(MEM_to_WB_valid), 32'd1);
      check("alu result", mem_final_result,     32'h0000_1234);
      check("alu fdest",  32'(mem_fwd_dest),    32'd5);
      check("alu busy",   32'(mem_fwd_busy),    32'd0);
      check("alu pc",     mem_pc,               32'h1c00_0000);
      step();
      check("alu drain",  32'(mem_fwd_dest),    32'd0);

      // Loads with alignment and extension
      run_load("ldb",  LD_B,  32'h0000_1003, 5'd9, 32'h80FF_7F01, 3, 32'hFFFF_FF80);
      run_load("ldhu", LD_HU, 32'h0000_1002, 5'd9, 32'h80FF_7F01, 3, 32'h0000_80FF);
      run_load("ldh",  LD_H,  32'h0000_1000, 5'd9, 32'h80FF_7F01, 3, 32'h0000_7F01);
      run_load("ldbu", LD_BU, 32'h0000_1001, 5'd9, 32'h80FF_7F01, 2, 32'h0000_007F);
      run_load("ldw7", LD_W,  32'h0000_2000, 5'd7, 32'hA5A5_A5A5, 1, 32'hA5A5_A5A5);

      // Flush in WAIT; new load captured later must skip the stale response
      drive_ex(LD_W, 1'b1, 32'h0000_0100, 5'd3, 32'h1c00_0200);
      step();
      idle_ex();
      wb_flush = 1'b1;
      #1;
      check("fl towb", 32'(MEM_to_WB_valid), 32'd0);
      step();
      wb_flush = 1'b0;
      #1;
      check("fl fdest", 32'(mem_fwd_dest), 32'd0);
      check("fl allow", 32'(MEM_allow),    32'd1);
      drive_ex(LD_W, 1'b1, 32'h0000_0104, 5'd4, 32'h1c00_0204);
      step();
      idle_ex();
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = 32'hDEAD_0000;
      #1;
      check("fl stale busy", 32'(mem_fwd_busy), 32'd1);
      step();
      data_sram_data_ok = 1'b0;
      #1;
      check("fl stale towb", 32'(MEM_to_WB_valid), 32'd0);
      check("fl stale busy2", 32'(mem_fwd_busy),   32'd1);
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = 32'h00C0_FFEE;
      step();
      data_sram_data_ok = 1'b0;
      #1;
      check("fl new towb",   32'(MEM_to_WB_valid), 32'd1);
      check("fl new result", mem_final_result,     32'h00C0_FFEE);
      step();

      // Flush in WAIT; stale response arrives in the same cycle as the next capture
      drive_ex(LD_W, 1'b1, 32'h0000_0108, 5'd3, 32'h1c00_0300);
      step();
      idle_ex();
      wb_flush = 1'b1;
      step();
      wb_flush = 1'b0;
      drive_ex(LD_W, 1'b1, 32'h0000_010C, 5'd6, 32'h1c00_0304);
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = 32'hDEAD_0000;
      step();
      idle_ex();
      data_sram_data_ok = 1'b0;
      #1;
      check("sc towb", 32'(MEM_to_WB_valid), 32'd0);
      check("sc busy", 32'(mem_fwd_busy),    32'd1);
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = 32'h0BAD_F00D;
      step();
      data_sram_data_ok = 1'b0;
      #1;
      check("sc result", mem_final_result, 32'h0BAD_F00D);
      step();

      // Flush in READY blocks the capture offered that cycle
      drive_ex(ALU, 1'b0, 32'h0000_4444, 5'd8, 32'h1c00_0400);
      step();
      drive_ex(ALU, 1'b0, 32'h0000_5555, 5'd9, 32'h1c00_0404);
      wb_flush = 1'b1;
      #1;
      check("flr towb",  32'(MEM_to_WB_valid), 32'd0);
      step();
      idle_ex();
      wb_flush = 1'b0;
      #1;
      check("flr fdest", 32'(mem_fwd_dest),    32'd0);
      check("flr towb2", 32'(MEM_to_WB_valid), 32'd0);
      step();

      // WB back-pressure holds MEM and EX
      drive_ex(ALU, 1'b0, 32'h0000_C0C0, 5'd10, 32'h1c00_0500);
      step();
      drive_ex(ALU, 1'b0, 32'h0000_D0D0, 5'd11, 32'h1c00_0504);
      WB_allow = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         check("bp allow",  32'(MEM_allow),       32'd0);
         check("bp towb",   32'(MEM_to_WB_valid), 32'd1);
         check("bp result", mem_final_result,     32'h0000_C0C0);
         step();
      end
      WB_allow = 1'b1;
      #1;
      check("bp release", 32'(MEM_allow), 32'd1);
      step();
      idle_ex();
      #1;
      check("bp next result", mem_final_result, 32'h0000_D0D0);
      check("bp next dest",   32'(mem_dest),    32'd11);
      step();

      // Back-to-back loads reach WB in order
      drive_ex(LD_W, 1'b1, 32'h0000_0200, 5'd12, 32'h1c00_0600);
      step();
      idle_ex();
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = 32'h1111_1111;
      step();
      data_sram_data_ok = 1'b0;
      drive_ex(LD_W, 1'b1, 32'h0000_0204, 5'd13, 32'h1c00_0604);
      #1;
      check("b2b 1 towb",   32'(MEM_to_WB_valid), 32'd1);
      check("b2b 1 result", mem_final_result,     32'h1111_1111);
      check("b2b 1 dest",   32'(mem_dest),        32'd12);
      step();
      idle_ex();
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = 32'h2222_2222;
      step();
      data_sram_data_ok = 1'b0;
      #1;
      check("b2b 2 towb",   32'(MEM_to_WB_valid), 32'd1);
      check("b2b 2 result", mem_final_result,     32'h2222_2222);
      check("b2b 2 dest",   32'(mem_dest),        32'd13);
      step();

      // Exception indication
      drive_ex(ALU, 1'b0, 32'h0000_0001, 5'd1, 32'h1c00_0700);
      ex_has_ex = 1'b1;
      step();
      idle_ex();
      #1;
      check("ex hasex", 32'(mem_ex), 32'd1);
      step();
      check("ex idle",  32'(mem_ex), 32'd0);
      drive_ex(ALU, 1'b0, 32'h0000_0002, 5'd1, 32'h1c00_0704);
      ex_pass[0] = 1'b1;
      step();
      idle_ex();
      #1;
      check("ex ertn", 32'(mem_ex),     32'd1);
      check("ex pass", mem_pass[31:0],  32'd1);
      step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
`default_nettype wire
